keypad_scan_ctrl: RTL

- Row-scanning controller for a ROWS x COLS matrix keypad.
- Sequences the row drives and samples the column lines once per row slot.
- Debounces every key with a per-key frame counter.
- Serialises debounced press/release changes into a valid/ready event stream for the host logic.
- Sits between the board-level key matrix pins and the command/UI logic. It replaces one standalone debouncer per key.

---
 rtl/keypad_scan_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning matrix keypad controller: drives one row per slot, debounces every key
// over whole scan frames and streams press/release changes over a valid/ready port.
module keypad_scan_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4,
    parameter int N_BOUNCE = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic [COLS-1:0]              i_col_n,
    output logic [ROWS-1:0]              o_row_n,
    output logic [ROWS*COLS-1:0]         o_key_state,
    output logic                         o_evt_valid,
    output logic [$clog2(ROWS*COLS)-1:0] o_evt_code,
    output logic                         o_evt_press,
    input  logic                         i_evt_ready,
    output logic                         o_frame_tick
);
    localparam int NKEYS  = ROWS * COLS;
    localparam int CODE_W = $clog2(NKEYS);
    localparam int ROW_W  = $clog2(ROWS);

    localparam logic [SCAN_DIV-1:0] SLOT_LAST = '1;
    localparam logic [SCAN_DIV-1:0] SLOT_ONE  = SCAN_DIV'(1);
    localparam logic [ROW_W-1:0]    ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]    ROW_ONE   = ROW_W'(1);
    localparam logic [N_BOUNCE-1:0] CNT_MAX   = '1;
    localparam logic [N_BOUNCE-1:0] CNT_ONE   = N_BOUNCE'(1);

    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scanState_t;

    scanState_t r_state;
    scanState_t w_stateNext;

    logic [COLS-1:0]     r_colMeta;
    logic [COLS-1:0]     r_colSync;
    logic [SCAN_DIV-1:0] r_slotCnt;
    logic [ROW_W-1:0]    r_rowIdx;
    logic [ROWS-1:0]     r_rowN;
    logic                r_frameTick;

    logic                w_count;
    logic                w_sample;
    logic [ROW_W-1:0]    w_rowNext;
    logic [ROWS-1:0]     w_rowDriveN;

    logic [NKEYS-1:0]    r_keyState;
    logic [N_BOUNCE-1:0] r_bounceCnt [NKEYS];

    logic [NKEYS-1:0]    r_reported;
    logic                r_evtValid;
    logic [CODE_W-1:0]   r_evtCode;
    logic                r_evtPress;

    logic                w_handshake;
    logic                w_load;
    logic [NKEYS-1:0]    w_reportedNext;
    logic [NKEYS-1:0]    w_pending;
    logic                w_pendAny;
    logic [CODE_W-1:0]   w_pendIdx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_colMeta <= '1;
            r_colSync <= '1;
        end else begin
            r_colMeta <= i_col_n;
            r_colSync <= r_colMeta;
        end
    end

    // IDLE is the arming cycle: the row is driven first, so every slot gets its full length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCAN_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (i_en) begin
            w_stateNext = SCAN_RUN;
        end else begin
            w_stateNext = SCAN_IDLE;
        end
    end

    always_comb begin
        w_count  = 1'b0;
        w_sample = 1'b0;
        if (r_state == SCAN_RUN && i_en) begin
            w_count  = 1'b1;
            w_sample = (r_slotCnt == SLOT_LAST);
        end
    end

    always_comb begin
        w_rowNext = r_rowIdx;
        if (w_sample) begin
            w_rowNext = (r_rowIdx == ROW_LAST) ? '0 : r_rowIdx + ROW_ONE;
        end
        w_rowDriveN = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (w_rowNext == ROW_W'(r)) begin
                w_rowDriveN[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotCnt   <= '0;
            r_rowIdx    <= '0;
            r_rowN      <= '1;
            r_frameTick <= 1'b0;
        end else begin
            r_frameTick <= w_sample && (r_rowIdx == ROW_LAST);
            if (!i_en) begin
                r_slotCnt <= '0;
                r_rowN    <= '1;
            end else begin
                if (w_count) begin
                    r_slotCnt <= r_slotCnt + SLOT_ONE;
                end
                r_rowIdx <= w_rowNext;
                r_rowN   <= w_rowDriveN;
            end
        end
    end

    // Only the keys on the row being sampled move; a single agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keyState <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                r_bounceCnt[k] <= '0;
            end
        end else if (w_sample) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r_rowIdx == ROW_W'(r)) begin
                        if (!r_colSync[c] == r_keyState[r*COLS+c]) begin
                            r_bounceCnt[r*COLS+c] <= '0;
                        end else if (r_bounceCnt[r*COLS+c] == CNT_MAX) begin
                            r_keyState[r*COLS+c]  <= !r_keyState[r*COLS+c];
                            r_bounceCnt[r*COLS+c] <= '0;
                        end else begin
                            r_bounceCnt[r*COLS+c] <= r_bounceCnt[r*COLS+c] + CNT_ONE;
                        end
                    end
                end
            end
        end
    end

    // The accepted event is folded into the reported view before picking the next key,
    // so back-to-back events never repeat the key just sent.
    always_comb begin
        w_handshake    = r_evtValid && i_evt_ready;
        w_load         = !r_evtValid || w_handshake;
        w_reportedNext = r_reported;
        if (w_handshake) begin
            w_reportedNext[r_evtCode] = r_evtPress;
        end
        w_pending = r_keyState ^ w_reportedNext;
        w_pendAny = |w_pending;
        w_pendIdx = '0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (w_pending[k]) begin
                w_pendIdx = CODE_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reported <= '0;
            r_evtValid <= 1'b0;
            r_evtCode  <= '0;
            r_evtPress <= 1'b0;
        end else begin
            r_reported <= w_reportedNext;
            if (w_load) begin
                r_evtValid <= w_pendAny;
                if (w_pendAny) begin
                    r_evtCode  <= w_pendIdx;
                    r_evtPress <= r_keyState[w_pendIdx];
                end
            end
        end
    end

    assign o_row_n      = r_rowN;
    assign o_key_state  = r_keyState;
    assign o_evt_valid  = r_evtValid;
    assign o_evt_code   = r_evtCode;
    assign o_evt_press  = r_evtPress;
    assign o_frame_tick = r_frameTick;

endmodule
